sram_match_scheduler: RTL and testbench
=======================================

Name: sram_match_scheduler

Overview:
Central scheduler shared by all per-port write matchers. Each cycle it gives every port a candidate SRAM index to probe, chosen so that no two ports probe the same SRAM in the same cycle. It also owns the SRAM lock table: it grants, refuses and releases exclusive write ownership, using round-robin arbitration when ports collide. It drives each matcher's accessible and viscous inputs.

Parameters:
PORT_NUM, 16, number of write ports (fixed, 4-bit port id)
SRAM_NUM, 32, number of SRAM banks (fixed, 5-bit index)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
match_mode  in  2  0 static, 1 semi-dynamic, 2/3 full-dynamic
lock_req  in  16  per-port one-cycle pulse requesting ownership of lock_sram[p]
lock_sram  in  80  per-port 5-bit requested SRAM, slice p*5+:5
lock_release  in  16  per-port pulse releasing that port's owned SRAM
lock_ack  out  16  per-port pulse, request granted
lock_nack  out  16  per-port pulse, request refused
matching_sram  out  80  per-port candidate SRAM for this cycle, slice p*5+:5
accessible  out  16  per-port: candidate SRAM is unlocked or owned by port p
viscous  out  16  per-port: port p currently owns an SRAM
sram_locked  out  32  lock bitmap, for debug and monitoring

Behaviour:
- Reset (async assert): scan_tick=0, all locks clear, rr_ptr=0, all outputs 0, matching_sram = mode-0 pattern after release. Every lock is lost when reset arrives mid-operation.
- scan_tick: 5-bit, increments every cycle and wraps 31->0. It is forced to 0 in the cycle after match_mode changes.
- matching_sram is registered and computed from the next scan_tick:
  mode 0: {p[3:0], tick[0]}, so 2 fixed SRAMs per port.
  mode 1: {p[0], p[3:0]+tick[3:0] (mod 16)}.
  mode 2/3: (2*p + tick) mod 32.
  In every mode the 16 indices in any one cycle are pairwise distinct. This is an invariant.
- accessible[p] is combinational: ~sram_locked[s] | (owner[s]==p), where s = matching_sram[p].
- viscous[p] = has_lock[p]. Each port owns at most one SRAM.
- Lock pipeline: requests are sampled at edge N and ack/nack are registered pulses in cycle N+1. Order of evaluation within one cycle:
  1. Releases first. Release with no owned SRAM is ignored.
  2. Request for an SRAM already owned by the requester: ack, no change.
  3. Request for an SRAM locked by another port (after step 1): nack.
  4. Requests for a free SRAM: the winner is the first requesting port at or after rr_ptr, scanning upward mod 16. Winner gets ack; all others for that SRAM get nack. Distinct SRAMs are arbitrated independently in the same cycle.
  5. A granted port that already owned a different SRAM frees the old one atomically in the same update.
- rr_ptr advances to (highest-index winner this cycle)+1 mod 16. It is unchanged if nothing was granted.
- Release and request on the same port in the same cycle: release first, then the request is evaluated normally.
- lock_ack and lock_nack are never both high for the same port.
- The lock table updates at the same edge as ack. sram_locked and accessible reflect the new owner in cycle N+1.

Decomposition:
- Shared package hydra_pkg holds: PORT_NUM/SRAM_NUM localparams, port_id_t (4b), sram_id_t (5b), and MATCH_STATIC / MATCH_SEMI / MATCH_FULL encodings.
- One sub-module, sram_lock_arbiter: a 16-way round-robin pick for one SRAM index, instantiated 32 times. It takes a request mask and rr_ptr and returns a one-hot grant.

Test Plan:
- Reset then run mode 2 for 32 cycles -> port 3 matching_sram steps 6,7,...,31,0,...,5. In every cycle all 16 indices are distinct, and all accessible=1.
- Mode 0, port 5 -> matching_sram alternates 10,11. Switch to mode 1 -> tick restarts at 0 and port 5 shows {1, 5+tick}, i.e. 21,22,...
- Ports 2 and 9 request SRAM 7 together with rr_ptr=0 -> ack[2], nack[9]. sram_locked[7]=1, viscous[2]=1, and accessible[9]=0 when port 9 probes 7. rr_ptr becomes 3.
- Port 2 releases SRAM 7 while port 9 requests 7 in the same cycle -> ack[9], owner[7]=9.
- Port 4 owns SRAM 12 and requests 20 -> ack, sram_locked[12]=0, sram_locked[20]=1. Port 4 then re-requests 20 -> ack, no change.
- rst_n asserted mid-cycle while locks are held -> sram_locked=0, viscous=0 and ack/nack=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hydra_pkg.sv
// Shared types and constants for the write-port / SRAM match scheduler.
package hydra_pkg;

  localparam int unsigned PORT_NUM = 16;
  localparam int unsigned SRAM_NUM = 32;

  typedef logic [3:0] port_id_t;
  typedef logic [4:0] sram_id_t;

  typedef enum logic [1:0] {
    MATCH_STATIC = 2'd0,
    MATCH_SEMI   = 2'd1,
    MATCH_FULL   = 2'd2
  } match_mode_e;

  // Candidate SRAM for one port at a given scan tick. Each mode keeps the
  // 16 per-port indices pairwise distinct for any single tick value.
  function automatic sram_id_t sched_index(input logic [1:0] mode,
                                           input port_id_t   port,
                                           input sram_id_t   tick);
    logic [3:0] rot;
    rot = port + tick[3:0];
    if (mode == MATCH_STATIC) begin
      return {port, tick[0]};
    end else if (mode == MATCH_SEMI) begin
      return {port[0], rot};
    end else begin
      return {port, 1'b0} + tick;
    end
  endfunction

endpackage

// File: rtl/sram_lock_arbiter.sv
// 16-way round-robin pick for one SRAM index: the first requesting port at
// or after rr_ptr (scanning upward, wrapping) receives a one-hot grant.
module sram_lock_arbiter
  import hydra_pkg::*;
(
  input  logic [PORT_NUM-1:0] req,
  input  port_id_t            rr_ptr,
  output logic [PORT_NUM-1:0] grant
);

  logic     found;
  port_id_t idx;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      idx = rr_ptr + port_id_t'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_match_scheduler.sv
// Central match scheduler: hands every write port a distinct candidate SRAM
// each cycle and owns the SRAM lock table (grant / refuse / release).
module sram_match_scheduler
  import hydra_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            match_mode,
  input  logic [PORT_NUM-1:0]   lock_req,
  input  logic [PORT_NUM*5-1:0] lock_sram,
  input  logic [PORT_NUM-1:0]   lock_release,
  output logic [PORT_NUM-1:0]   lock_ack,
  output logic [PORT_NUM-1:0]   lock_nack,
  output logic [PORT_NUM*5-1:0] matching_sram,
  output logic [PORT_NUM-1:0]   accessible,
  output logic [PORT_NUM-1:0]   viscous,
  output logic [SRAM_NUM-1:0]   sram_locked
);

  // Scan schedule state
  sram_id_t              tick_q, tick_d;
  logic [1:0]            mode_q, mode_d;
  logic [PORT_NUM*5-1:0] matching_sram_q, matching_sram_d;

  // Lock table state
  logic [SRAM_NUM-1:0]   locked_q, locked_d;
  port_id_t              owner_q [SRAM_NUM];
  port_id_t              owner_d [SRAM_NUM];
  port_id_t              rr_q, rr_d;
  logic [PORT_NUM-1:0]   ack_q, ack_d;
  logic [PORT_NUM-1:0]   nack_q, nack_d;

  // Intermediate lock evaluation
  logic [SRAM_NUM-1:0]   locked_rel;
  logic [PORT_NUM-1:0]   req_mask   [SRAM_NUM];
  logic [PORT_NUM-1:0]   grant_mask [SRAM_NUM];
  logic [PORT_NUM-1:0]   won;
  sram_id_t              req_s;
  sram_id_t              cur_s;
  sram_id_t              acc_s;
  logic [PORT_NUM-1:0]   acc;
  logic [PORT_NUM-1:0]   visc;

  // Next scan tick and the registered candidate pattern derived from it.
  always_comb begin
    mode_d          = match_mode;
    tick_d          = (match_mode != mode_q) ? '0 : tick_q + 5'd1;
    matching_sram_d = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      matching_sram_d[p*5 +: 5] = sched_index(match_mode, port_id_t'(p), tick_d);
    end
  end

  // Scan schedule registers; reset leaves the static pattern at tick 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      mode_q <= MATCH_STATIC;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        matching_sram_q[p*5 +: 5] <= {port_id_t'(p), 1'b0};
      end
    end else begin
      tick_q          <= tick_d;
      mode_q          <= mode_d;
      matching_sram_q <= matching_sram_d;
    end
  end

  // Apply releases, then collect requests that target SRAMs left free.
  always_comb begin
    locked_rel = locked_q;
    req_s      = '0;
    for (int unsigned s = 0; s < SRAM_NUM; s++) begin
      if (locked_q[s] && lock_release[owner_q[s]]) begin
        locked_rel[s] = 1'b0;
      end
      req_mask[s] = '0;
    end
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      req_s = lock_sram[p*5 +: 5];
      if (lock_req[p] && !locked_rel[req_s]) begin
        req_mask[req_s][p] = 1'b1;
      end
    end
  end

  // One round-robin picker per SRAM; all share the same pointer.
  for (genvar s = 0; s < SRAM_NUM; s++) begin : g_arb
    sram_lock_arbiter u_arb (
      .req    (req_mask[s]),
      .rr_ptr (rr_q),
      .grant  (grant_mask[s])
    );
  end

  // Ack/nack decisions, ownership moves and round-robin pointer update.
  // Old SRAMs of winners are freed before new owners are written; a newly
  // granted SRAM was free after releases, so the two never collide.
  always_comb begin
    ack_d    = '0;
    nack_d   = '0;
    won      = '0;
    locked_d = locked_rel;
    rr_d     = rr_q;
    cur_s    = '0;
    for (int unsigned s = 0; s < SRAM_NUM; s++) begin
      owner_d[s] = owner_q[s];
    end
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      cur_s = lock_sram[p*5 +: 5];
      if (lock_req[p]) begin
        if (locked_rel[cur_s]) begin
          if (owner_q[cur_s] == port_id_t'(p)) begin
            ack_d[p] = 1'b1;
          end else begin
            nack_d[p] = 1'b1;
          end
        end else if (grant_mask[cur_s][p]) begin
          ack_d[p] = 1'b1;
          won[p]   = 1'b1;
          rr_d     = port_id_t'(p) + 4'd1;
        end else begin
          nack_d[p] = 1'b1;
        end
      end
    end
    for (int unsigned s = 0; s < SRAM_NUM; s++) begin
      if (locked_rel[s] && won[owner_q[s]]) begin
        locked_d[s] = 1'b0;
      end
    end
    for (int unsigned s = 0; s < SRAM_NUM; s++) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (grant_mask[s][p]) begin
          locked_d[s] = 1'b1;
          owner_d[s]  = port_id_t'(p);
        end
      end
    end
  end

  // Lock table and response registers; reset drops every lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= '0;
      rr_q     <= '0;
      ack_q    <= '0;
      nack_q   <= '0;
      for (int unsigned s = 0; s < SRAM_NUM; s++) begin
        owner_q[s] <= '0;
      end
    end else begin
      locked_q <= locked_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      for (int unsigned s = 0; s < SRAM_NUM; s++) begin
        owner_q[s] <= owner_d[s];
      end
    end
  end

  // Candidate is usable when it is unlocked or already held by this port.
  always_comb begin
    acc   = '0;
    acc_s = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      acc_s  = matching_sram_q[p*5 +: 5];
      acc[p] = !locked_q[acc_s] || (owner_q[acc_s] == port_id_t'(p));
    end
  end

  // A port is viscous while it owns any SRAM.
  always_comb begin
    visc = '0;
    for (int unsigned s = 0; s < SRAM_NUM; s++) begin
      if (locked_q[s]) begin
        visc[owner_q[s]] = 1'b1;
      end
    end
  end

  assign lock_ack      = ack_q;
  assign lock_nack     = nack_q;
  assign matching_sram = matching_sram_q;
  assign accessible    = acc;
  assign viscous       = visc;
  assign sram_locked   = locked_q;

endmodule

// File: tb/tb_sram_match_scheduler.sv
// Self-checking bench for sram_match_scheduler: behavioural model of the
// schedule and lock table, directed scenarios, then randomized traffic.
module tb_sram_match_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  match_mode = 2'd0;
  logic [15:0] lock_req = '0;
  logic [79:0] lock_sram = '0;
  logic [15:0] lock_release = '0;
  logic [15:0] lock_ack, lock_nack, accessible, viscous;
  logic [79:0] matching_sram;
  logic [31:0] sram_locked;

  sram_match_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .match_mode    (match_mode),
    .lock_req      (lock_req),
    .lock_sram     (lock_sram),
    .lock_release  (lock_release),
    .lock_ack      (lock_ack),
    .lock_nack     (lock_nack),
    .matching_sram (matching_sram),
    .accessible    (accessible),
    .viscous       (viscous),
    .sram_locked   (sram_locked)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Model state: owner per SRAM (-1 = free), scan tick, last mode, rr pointer.
  int m_owner [32];
  int m_tick, m_prev, m_rr;
  int req_sram [16];

  logic [79:0] exp_match;
  logic [15:0] exp_ack, exp_nack, exp_acc, exp_visc;
  logic [31:0] exp_locked;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int port_match(input int p);
    return int'(matching_sram[p*5 +: 5]);
  endfunction

  task automatic derive_outputs();
    exp_locked = '0;
    exp_visc   = '0;
    exp_acc    = '0;
    for (int s = 0; s < 32; s++) begin
      if (m_owner[s] >= 0) begin
        exp_locked[s]          = 1'b1;
        exp_visc[m_owner[s]]   = 1'b1;
      end
    end
    for (int p = 0; p < 16; p++) begin
      int s;
      s = int'(exp_match[p*5 +: 5]);
      exp_acc[p] = (m_owner[s] < 0) || (m_owner[s] == p);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_prev = 0; m_rr = 0;
    for (int s = 0; s < 32; s++) m_owner[s] = -1;
    for (int p = 0; p < 16; p++) exp_match[p*5 +: 5] = 5'(2 * p);
    exp_ack = '0; exp_nack = '0;
    derive_outputs();
  endtask

  // Expected state after the coming clock edge, from the current inputs.
  task automatic model_step();
    int win_sram [16];
    int hi;
    bit any;
    if (int'(match_mode) != m_prev) m_tick = 0;
    else m_tick = (m_tick + 1) % 32;
    m_prev = int'(match_mode);
    for (int p = 0; p < 16; p++) begin
      int v;
      if (match_mode == 2'd0)      v = 2 * p + (m_tick % 2);
      else if (match_mode == 2'd1) v = (p % 2) * 16 + (p + m_tick) % 16;
      else                         v = (2 * p + m_tick) % 32;
      exp_match[p*5 +: 5] = 5'(v);
    end
    for (int p = 0; p < 16; p++)
      if (lock_release[p])
        for (int s = 0; s < 32; s++) if (m_owner[s] == p) m_owner[s] = -1;
    exp_ack = '0; exp_nack = '0;
    for (int p = 0; p < 16; p++) win_sram[p] = -1;
    for (int s = 0; s < 32; s++) begin
      if (m_owner[s] >= 0) begin
        for (int p = 0; p < 16; p++)
          if (lock_req[p] && req_sram[p] == s) begin
            if (m_owner[s] == p) exp_ack[p] = 1'b1;
            else exp_nack[p] = 1'b1;
          end
      end else begin
        int w;
        w = -1;
        for (int k = 0; k < 16; k++) begin
          int q;
          q = (m_rr + k) % 16;
          if (w < 0 && lock_req[q] && req_sram[q] == s) w = q;
        end
        if (w >= 0) begin
          win_sram[w] = s;
          for (int p = 0; p < 16; p++)
            if (lock_req[p] && req_sram[p] == s) begin
              if (p == w) exp_ack[p] = 1'b1;
              else exp_nack[p] = 1'b1;
            end
        end
      end
    end
    any = 1'b0; hi = 0;
    for (int p = 0; p < 16; p++)
      if (win_sram[p] >= 0)
        for (int s = 0; s < 32; s++) if (m_owner[s] == p) m_owner[s] = -1;
    for (int p = 0; p < 16; p++)
      if (win_sram[p] >= 0) begin
        m_owner[win_sram[p]] = p;
        any = 1'b1;
        hi  = p;
      end
    if (any) m_rr = (hi + 1) % 16;
    derive_outputs();
  endtask

  // Called just after a falling edge: apply inputs, advance model, wait.
  task automatic cycle();
    for (int p = 0; p < 16; p++) lock_sram[p*5 +: 5] = 5'(req_sram[p]);
    model_step();
    @(negedge clk);
    #1;
    lock_req     = '0;
    lock_release = '0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("matching_sram", matching_sram, exp_match);
      chk("lock_ack",      lock_ack,      exp_ack);
      chk("lock_nack",     lock_nack,     exp_nack);
      chk("sram_locked",   sram_locked,   exp_locked);
      chk("accessible",    accessible,    exp_acc);
      chk("viscous",       viscous,       exp_visc);
    end
  end

  initial begin
    int dups;
    bit seen;
    for (int p = 0; p < 16; p++) req_sram[p] = 0;
    model_reset();
    match_mode = 2'd2;
    #12;
    chk("reset_matching", matching_sram, exp_match);
    chk("reset_port7_sram", matching_sram[35 +: 5], 80'd14);
    chk("reset_locked", sram_locked, 80'd0);
    chk("reset_ack_nack", {lock_ack, lock_nack, viscous}, 80'd0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Mode 2 sweep: port 3 walks 6..31,0..5, indices distinct, all accessible.
    for (int i = 0; i < 32; i++) begin
      cycle();
      chk("mode2_port3", port_match(3), (6 + i) % 32);
      dups = 0;
      for (int a = 0; a < 16; a++)
        for (int b = a + 1; b < 16; b++)
          if (port_match(a) == port_match(b)) dups++;
      chk("mode2_distinct", dups, 0);
      chk("mode2_accessible", accessible, 80'hFFFF);
    end

    // Mode 0 then mode 1 for port 5.
    match_mode = 2'd0;
    cycle(); chk("mode0_p5_a", port_match(5), 10);
    cycle(); chk("mode0_p5_b", port_match(5), 11);
    cycle(); chk("mode0_p5_c", port_match(5), 10);
    match_mode = 2'd1;
    cycle(); chk("mode1_p5_a", port_match(5), 21);
    cycle(); chk("mode1_p5_b", port_match(5), 22);

    // Collision on SRAM 7 with rr at 0.
    match_mode = 2'd2;
    lock_req[2] = 1'b1; req_sram[2] = 7;
    lock_req[9] = 1'b1; req_sram[9] = 7;
    cycle();
    chk("coll_ack2", lock_ack[2], 1);
    chk("coll_nack9", lock_nack[9], 1);
    chk("coll_ack9_low", lock_ack[9], 0);
    chk("coll_locked7", sram_locked[7], 1);
    chk("coll_viscous2", viscous[2], 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (port_match(9) == 7) begin
        chk("p9_probe7_inaccessible", accessible[9], 0);
        seen = 1'b1;
      end
    end
    chk("p9_probe7_seen", seen, 1);

    // Release and re-request of SRAM 7 in the same cycle.
    lock_release[2] = 1'b1;
    lock_req[9] = 1'b1; req_sram[9] = 7;
    cycle();
    chk("handover_ack9", lock_ack[9], 1);
    chk("handover_viscous", {viscous[9], viscous[2]}, 2'b10);
    chk("handover_locked7", sram_locked[7], 1);

    // Port 4 moves from SRAM 12 to 20, then re-requests 20.
    lock_req[4] = 1'b1; req_sram[4] = 12; cycle();
    chk("p4_ack12", lock_ack[4], 1);
    lock_req[4] = 1'b1; req_sram[4] = 20; cycle();
    chk("p4_ack20", lock_ack[4], 1);
    chk("p4_move_locks", {sram_locked[20], sram_locked[12]}, 2'b10);
    lock_req[4] = 1'b1; req_sram[4] = 20; cycle();
    chk("p4_rereq", {lock_ack[4], lock_nack[4], sram_locked[20]}, 3'b101);

    // Round-robin pointer now 5: port 11 beats port 1; then wraps from 12.
    lock_req[1] = 1'b1; req_sram[1] = 25;
    lock_req[11] = 1'b1; req_sram[11] = 25;
    cycle();
    chk("rr_ack11", {lock_ack[11], lock_nack[1]}, 2'b11);
    lock_req[1] = 1'b1; req_sram[1] = 30;
    lock_req[3] = 1'b1; req_sram[3] = 30;
    cycle();
    chk("rr_wrap_ack1", {lock_ack[1], lock_nack[3]}, 2'b11);

    // Asynchronous reset with locks held and an ack pulse showing.
    lock_req[0] = 1'b1; req_sram[0] = 0;
    cycle();
    chk("pre_reset_ack0", lock_ack[0], 1);
    chk("pre_reset_locked7", sram_locked[7], 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_locked", sram_locked, 80'd0);
    chk("async_viscous", viscous, 80'd0);
    chk("async_ack_nack", {lock_ack, lock_nack}, 80'd0);
    @(negedge clk); #1;
    model_reset();
    chk("async_matching", matching_sram, exp_match);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic with concentrated SRAM targets to force collisions.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) match_mode = 2'($urandom_range(0, 3));
      for (int p = 0; p < 16; p++) begin
        lock_req[p]     = ($urandom_range(0, 3) == 0);
        lock_release[p] = ($urandom_range(0, 7) == 0);
        req_sram[p]     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                      : int'($urandom_range(0, 7));
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
